// File: rtl/iq_pkg.sv
// iq_pkg: shared types and helpers for the issue queue, dispatch and operand fetch.
//   TAG_W, SQN_W, FU_W : field widths of a renamed uop
//   IQ_PAYLOAD_W       : width of the opaque payload carried through untouched
//   iq_uop_t           : uop as enqueued and as issued
//   sqn_older/younger  : wrap-safe age compares on sequence numbers
package iq_pkg;

    localparam int TAG_W        = 7;
    localparam int SQN_W        = 7;
    localparam int FU_W         = 3;
    localparam int IQ_PAYLOAD_W = 64;

    typedef struct packed {
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]        tagA;
        logic                    availA;
        logic [TAG_W-1:0]        tagB;
        logic                    availB;
        logic [SQN_W-1:0]        sqN;
        logic [FU_W-1:0]         fu;
    } iq_uop_t;

    // a older than b: signed (a - b) < 0
    function automatic logic sqn_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    // a younger than b: signed (a - b) > 0
    function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return !d[SQN_W-1] && (d != '0);
    endfunction

endpackage

// File: rtl/iq_select.sv
// iq_select: combinational oldest-ready picker.
//   req       : per-entry valid-and-ready
//   sqn       : per-entry sequence number
//   gnt_idx   : index of the oldest requesting entry
//   gnt_valid : at least one entry requested
module iq_select
    import iq_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]  req,
    input  logic [SQN_W-1:0] sqn [SIZE],
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // Heap-ordered tree: leaves at SIZE..2*SIZE-1, root at 1, node 0 unused.
    logic             node_v   [2*SIZE];
    logic [IDX_W-1:0] node_idx [2*SIZE];
    logic [SQN_W-1:0] node_sqn [2*SIZE];

    always_comb begin
        for (int unsigned n = 0; n < 2*SIZE; n++) begin
            node_v[n]   = 1'b0;
            node_idx[n] = '0;
            node_sqn[n] = '0;
        end
        for (int unsigned i = 0; i < SIZE; i++) begin
            node_v[SIZE+i]   = req[i];
            node_idx[SIZE+i] = IDX_W'(i);
            node_sqn[SIZE+i] = sqn[i];
        end
        for (int unsigned n = SIZE-1; n >= 1; n--) begin
            if (node_v[2*n] && (!node_v[2*n+1] || sqn_older(node_sqn[2*n], node_sqn[2*n+1]))) begin
                node_v[n]   = 1'b1;
                node_idx[n] = node_idx[2*n];
                node_sqn[n] = node_sqn[2*n];
            end else begin
                node_v[n]   = node_v[2*n+1];
                node_idx[n] = node_idx[2*n+1];
                node_sqn[n] = node_sqn[2*n+1];
            end
        end
        gnt_idx   = node_idx[1];
        gnt_valid = node_v[1];
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: single-lane out-of-order issue queue.
//   clk, rst (sync, active-high)
//   IN_enqValid/IN_enqUop      : enqueue port (lowest free slot)
//   OUT_full                   : registered, occupancy == SIZE
//   IN_wbHasResult/IN_wbTag    : writeback wakeup ports
//   IN_invalidate/_SqN         : flush everything younger than _SqN
//   IN_stall                   : operand fetch cannot accept
//   OUT_valid/OUT_uop          : registered issue slot (avail bits forced to 1)
module issue_queue
    import iq_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int NUM_WBS   = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_enqValid,
    input  iq_uop_t                  IN_enqUop,
    output logic                     OUT_full,
    input  logic [NUM_WBS-1:0]       IN_wbHasResult,
    input  logic [NUM_WBS*TAG_W-1:0] IN_wbTag,
    input  logic                     IN_invalidate,
    input  logic [SQN_W-1:0]         IN_invalidateSqN,
    input  logic                     IN_stall,
    output logic                     OUT_valid,
    output iq_uop_t                  OUT_uop
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int CNT_W = IDX_W + 1;

    if (PAYLOAD_W != IQ_PAYLOAD_W) begin : g_payload_w_check
        $error("issue_queue: PAYLOAD_W must match iq_pkg::IQ_PAYLOAD_W");
    end

    iq_uop_t          ent    [SIZE];
    iq_uop_t          ent_wk [SIZE];
    logic [SQN_W-1:0] sqns   [SIZE];
    logic [SIZE-1:0]  vld;
    logic [SIZE-1:0]  req;
    logic [SIZE-1:0]  kill;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] kill_cnt;
    logic [CNT_W-1:0] count_nxt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             do_issue;
    logic             do_enq;
    iq_uop_t          enq_wk;
    logic             out_valid_nxt;
    iq_uop_t          out_uop_nxt;

    function automatic iq_uop_t wake(input iq_uop_t u, input logic [NUM_WBS-1:0] has,
                                     input logic [NUM_WBS*TAG_W-1:0] tags);
        iq_uop_t r;
        r = u;
        for (int unsigned j = 0; j < NUM_WBS; j++) begin
            if (has[j] && !u.tagA[TAG_W-1] && tags[j*TAG_W +: TAG_W] == u.tagA) r.availA = 1'b1;
            if (has[j] && !u.tagB[TAG_W-1] && tags[j*TAG_W +: TAG_W] == u.tagB) r.availB = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        req      = '0;
        kill     = '0;
        kill_cnt = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            sqns[i]   = ent[i].sqN;
            ent_wk[i] = wake(ent[i], IN_wbHasResult, IN_wbTag);
            // readiness uses stored avail bits; same-cycle writebacks count from the next cycle
            req[i]    = vld[i] && (ent[i].tagA[TAG_W-1] || ent[i].availA)
                               && (ent[i].tagB[TAG_W-1] || ent[i].availB);
            kill[i]   = vld[i] && IN_invalidate && sqn_younger(ent[i].sqN, IN_invalidateSqN);
            kill_cnt  = kill_cnt + CNT_W'(kill[i]);
        end
    end

    iq_select #(.SIZE(SIZE), .IDX_W(IDX_W)) u_select (
        .req       (req),
        .sqn       (sqns),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (!vld[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
        enq_wk    = wake(IN_enqUop, IN_wbHasResult, IN_wbTag);
        do_issue  = !IN_stall && gnt_valid && !kill[gnt_idx];
        do_enq    = IN_enqValid && !OUT_full && free_found
                    && !(IN_invalidate && sqn_younger(IN_enqUop.sqN, IN_invalidateSqN));
        count_nxt = count + CNT_W'(do_enq) - CNT_W'(do_issue) - kill_cnt;

        out_valid_nxt = OUT_valid;
        out_uop_nxt   = OUT_uop;
        if (!IN_stall) begin
            out_valid_nxt = do_issue;
            if (do_issue) begin
                out_uop_nxt        = ent[gnt_idx];
                out_uop_nxt.availA = 1'b1;
                out_uop_nxt.availB = 1'b1;
            end
        end else if (IN_invalidate && OUT_valid && sqn_younger(OUT_uop.sqN, IN_invalidateSqN)) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            count     <= '0;
            OUT_full  <= 1'b0;
            OUT_valid <= 1'b0;
            OUT_uop   <= '0;
        end else begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                ent[i] <= ent_wk[i];
                if (kill[i] || (do_issue && gnt_idx == IDX_W'(i))) vld[i] <= 1'b0;
            end
            if (do_enq) begin
                ent[free_idx] <= enq_wk;
                vld[free_idx] <= 1'b1;
            end
            count     <= count_nxt;
            OUT_full  <= (count_nxt == CNT_W'(SIZE));
            OUT_valid <= out_valid_nxt;
            OUT_uop   <= out_uop_nxt;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed stimulus with a queue-based reference model of the
// issue queue and a per-cycle compare, plus literal expectations per scenario.
module tb_issue_queue;
    import iq_pkg::*;

    localparam int SIZE    = 8;
    localparam int NUM_WBS = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     IN_enqValid;
    iq_uop_t                  IN_enqUop;
    logic                     OUT_full;
    logic [NUM_WBS-1:0]       IN_wbHasResult;
    logic [NUM_WBS*TAG_W-1:0] IN_wbTag;
    logic                     IN_invalidate;
    logic [SQN_W-1:0]         IN_invalidateSqN;
    logic                     IN_stall;
    logic                     OUT_valid;
    iq_uop_t                  OUT_uop;

    int checks   = 0;
    int failures = 0;
    int proto_errs = 0;

    issue_queue #(.SIZE(SIZE), .NUM_WBS(NUM_WBS), .PAYLOAD_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .IN_enqValid      (IN_enqValid),
        .IN_enqUop        (IN_enqUop),
        .OUT_full         (OUT_full),
        .IN_wbHasResult   (IN_wbHasResult),
        .IN_wbTag         (IN_wbTag),
        .IN_invalidate    (IN_invalidate),
        .IN_invalidateSqN (IN_invalidateSqN),
        .IN_stall         (IN_stall),
        .OUT_valid        (OUT_valid),
        .OUT_uop          (OUT_uop)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    iq_uop_t mq[$];
    iq_uop_t m_out;
    logic    m_valid = 1'b0;
    logic    m_full  = 1'b0;
    logic    m_live  = 1'b0;

    function automatic bit m_is_older(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = a - b;
        return $signed(d) < 0;
    endfunction

    function automatic bit m_is_younger(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = a - b;
        return $signed(d) > 0;
    endfunction

    function automatic bit m_ready(input iq_uop_t u);
        return (u.tagA[6] || u.availA) && (u.tagB[6] || u.availB);
    endfunction

    function automatic iq_uop_t m_wake(input iq_uop_t u, input logic [NUM_WBS-1:0] has,
                                       input logic [NUM_WBS*7-1:0] tags);
        iq_uop_t r;
        logic [6:0] t;
        r = u;
        for (int j = 0; j < NUM_WBS; j++) begin
            t = tags[j*7 +: 7];
            if (has[j] && u.tagA[6] == 1'b0 && t == u.tagA) r.availA = 1'b1;
            if (has[j] && u.tagB[6] == 1'b0 && t == u.tagB) r.availB = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        iq_uop_t nq[$];
        int best;
        if (rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_out   = '0;
            m_full  = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            best = -1;
            foreach (mq[i])
                if (m_ready(mq[i]) && (best < 0 || m_is_older(mq[i].sqN, mq[best].sqN))) best = i;
            if (!IN_stall) begin
                if (best >= 0 && !(IN_invalidate && m_is_younger(mq[best].sqN, IN_invalidateSqN))) begin
                    m_out        = mq[best];
                    m_out.availA = 1'b1;
                    m_out.availB = 1'b1;
                    m_valid      = 1'b1;
                end else begin
                    m_valid = 1'b0;
                    best    = -1;
                end
            end else begin
                best = -1;
                if (IN_invalidate && m_valid && m_is_younger(m_out.sqN, IN_invalidateSqN)) m_valid = 1'b0;
            end
            nq.delete();
            foreach (mq[i])
                if (i != best && !(IN_invalidate && m_is_younger(mq[i].sqN, IN_invalidateSqN)))
                    nq.push_back(m_wake(mq[i], IN_wbHasResult, IN_wbTag));
            if (IN_enqValid) begin
                if (mq.size() == SIZE) begin
                    proto_errs++;
                    $display("protocol: enqueue sqN=%0d while full is ignored", IN_enqUop.sqN);
                end else if (!(IN_invalidate && m_is_younger(IN_enqUop.sqN, IN_invalidateSqN))) begin
                    nq.push_back(m_wake(IN_enqUop, IN_wbHasResult, IN_wbTag));
                end
            end
            mq     = nq;
            m_full = (mq.size() == SIZE);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            checks++;
            if (OUT_valid !== m_valid) begin
                failures++;
                $display("FAIL model_valid t=%0t got=%b exp=%b", $time, OUT_valid, m_valid);
            end
            checks++;
            if (OUT_full !== m_full) begin
                failures++;
                $display("FAIL model_full t=%0t got=%b exp=%b", $time, OUT_full, m_full);
            end
            if (m_valid) begin
                checks++;
                if (OUT_uop !== m_out) begin
                    failures++;
                    $display("FAIL model_uop t=%0t got=%h exp=%h", $time, OUT_uop, m_out);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic iq_uop_t mk(input logic [6:0] sq, input logic [6:0] ta, input logic aa,
                                   input logic [6:0] tb, input logic ab);
        iq_uop_t u;
        u.payload = {32'hC0DE_0000, 25'd0, sq};
        u.tagA    = ta;
        u.availA  = aa;
        u.tagB    = tb;
        u.availB  = ab;
        u.sqN     = sq;
        u.fu      = sq[2:0];
        return u;
    endfunction

    function automatic iq_uop_t rdy(input logic [6:0] sq);
        return mk(sq, 7'h40, 1'b0, 7'h41, 1'b0);
    endfunction

    task automatic enq(input iq_uop_t u);
        IN_enqValid = 1'b1;
        IN_enqUop   = u;
        tick();
        IN_enqValid = 1'b0;
    endtask

    task automatic expect_issue(input string name, input logic [6:0] sq);
        tick();
        lit({name, "_valid"}, 64'(OUT_valid), 64'd1);
        lit({name, "_sqn"}, 64'(OUT_uop.sqN), 64'(sq));
    endtask

    initial begin
        rst = 1'b1; IN_enqValid = 1'b0; IN_enqUop = '0; IN_wbHasResult = '0; IN_wbTag = '0;
        IN_invalidate = 1'b0; IN_invalidateSqN = '0; IN_stall = 1'b0;

        // reset state
        tick(); tick();
        rst = 1'b0;
        lit("reset_valid", 64'(OUT_valid), 64'd0);
        lit("reset_full", 64'(OUT_full), 64'd0);
        lit("reset_uop_sqn", 64'(OUT_uop.sqN), 64'd0);
        lit("reset_uop_payload", OUT_uop.payload, 64'd0);

        // wakeup gating
        enq(mk(7'd5, 7'h12, 1'b0, 7'h40, 1'b0));
        tick(); tick();
        lit("wake_wait", 64'(OUT_valid), 64'd0);
        IN_wbHasResult = 4'b0100;
        IN_wbTag[2*7 +: 7] = 7'h12;
        tick();
        IN_wbHasResult = '0; IN_wbTag = '0;
        lit("wake_edge_w", 64'(OUT_valid), 64'd0);
        expect_issue("wake_issue", 7'd5);
        lit("wake_availA", 64'(OUT_uop.availA), 64'd1);
        lit("wake_payload", OUT_uop.payload, 64'hC0DE_0000_0000_0005);
        tick();
        lit("wake_drained", 64'(OUT_valid), 64'd0);

        // wakeup in the enqueue cycle
        IN_wbHasResult = 4'b0001;
        IN_wbTag[6:0] = 7'h13;
        enq(mk(7'd20, 7'h13, 1'b0, 7'h41, 1'b0));
        IN_wbHasResult = '0; IN_wbTag = '0;
        lit("enqwake_n", 64'(OUT_valid), 64'd0);
        expect_issue("enqwake_issue", 7'd20);
        tick();

        // oldest first
        IN_stall = 1'b1;
        enq(rdy(7'd3)); enq(rdy(7'd1)); enq(rdy(7'd2));
        lit("oldest_held", 64'(OUT_valid), 64'd0);
        IN_stall = 1'b0;
        expect_issue("oldest_1", 7'd1);
        expect_issue("oldest_2", 7'd2);
        expect_issue("oldest_3", 7'd3);
        tick();

        // sqN wrap-around
        IN_stall = 1'b1;
        enq(rdy(7'd126)); enq(rdy(7'd2));
        IN_stall = 1'b0;
        expect_issue("wrap_126", 7'd126);
        expect_issue("wrap_2", 7'd2);
        tick();

        // stall with invalidate
        enq(rdy(7'd9));
        expect_issue("inv_setup", 7'd9);
        IN_stall = 1'b1;
        enq(rdy(7'd6)); enq(rdy(7'd8)); enq(rdy(7'd10));
        lit("inv_hold_sqn", 64'(OUT_uop.sqN), 64'd9);
        lit("inv_hold_valid", 64'(OUT_valid), 64'd1);
        IN_invalidate = 1'b1; IN_invalidateSqN = 7'd7;
        enq(rdy(7'd11));
        IN_invalidate = 1'b0;
        lit("inv_cleared", 64'(OUT_valid), 64'd0);
        IN_stall = 1'b0;
        expect_issue("inv_survivor", 7'd6);
        tick();
        lit("inv_rest_freed", 64'(OUT_valid), 64'd0);

        // full
        IN_stall = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            enq(rdy(7'(30 + i)));
            if (i == SIZE - 2) lit("full_at7", 64'(OUT_full), 64'd0);
        end
        lit("full_at8", 64'(OUT_full), 64'd1);
        enq(rdy(7'd38));
        lit("full_still", 64'(OUT_full), 64'd1);
        IN_stall = 1'b0;
        expect_issue("full_issue", 7'd30);
        lit("full_dropped", 64'(OUT_full), 64'd0);
        for (int i = 1; i < SIZE; i++) expect_issue("full_drain", 7'(30 + i));
        tick();
        lit("full_empty", 64'(OUT_valid), 64'd0);

        // reset mid-operation
        enq(rdy(7'd40));
        enq(rdy(7'd41));
        lit("rstmid_valid", 64'(OUT_valid), 64'd1);
        IN_stall = 1'b1;
        for (int i = 0; i < 4; i++) enq(rdy(7'(42 + i)));
        IN_stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit("rstmid_out", 64'(OUT_valid), 64'd0);
        lit("rstmid_full", 64'(OUT_full), 64'd0);
        enq(rdy(7'd50));
        lit("rstmid_n", 64'(OUT_valid), 64'd0);
        expect_issue("rstmid_new", 7'd50);
        tick();
        lit("rstmid_empty", 64'(OUT_valid), 64'd0);

        lit("protocol_errs", 64'(proto_errs), 64'd1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
